spi_slave_param: RTL
====================

# spi_slave_param

Parametrised SPI slave running entirely in the CTRL_CLK domain. It oversamples CS, SCLK and SDI through synchronisers and supports all four CPOL/CPHA modes, configurable word width, bit order and multi-word bursts. Its parallel side is a valid/ready TX holding register and an RX output register with sticky overrun/underrun flags. It is the slave-side counterpart to the team's SPI master and replaces the fixed 8-bit, mode-0-only slave.

## Interface
- DATA_W, 8: word width in bits, 2..32.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first on both SDI and SDO.
- SYNC_STAGES, 2: synchroniser depth for CS, SCLK and SDI, 2..3.
- CTRL_CLK  in  1  system clock; all logic rises on it.
- NRST  in  1  reset, synchronous, active-low.
- CS  in  1  chip select from master, active-low, asynchronous.
- SCLK  in  1  SPI clock from master, asynchronous.
- SDI  in  1  serial data from master.
- SDO  out  1  serial data to master; 0 whenever not selected.
- TX_DATA  in  DATA_W  next word to send.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  holding register empty.
- RX_DATA  out  DATA_W  last complete received word.
- RX_VALID  out  1  RX_DATA unread.
- RX_READY  in  1  consumer accepts RX_DATA.
- BUSY  out  1  high in LOAD/SHIFT.
- OVERRUN  out  1  sticky; a word completed while RX_VALID was still high.
- UNDERRUN  out  1  sticky; a word started with the holding register empty.

## Operation
- Synchronisers: CS_s, SCLK_s and SDI_s are SYNC_STAGES-flop versions of the pins. Edges come from comparing SCLK_s with a registered copy.
- Edge naming: leading = transition away from CPOL; trailing = transition back to CPOL.
- Sample edge is leading if CPHA=0, else trailing. Shift edge is the other one.
- States:
  - IDLE: SDO=0 and counter cleared. A CS_s fall goes to LOAD.
  - LOAD: exactly one cycle. The holding register moves to the TX shift register and TX_READY rises; if the holding register is empty, all zeros are loaded and UNDERRUN is set. For CPHA=0, SDO is driven with the first bit in this cycle. Then go to SHIFT.
  - SHIFT:
    - On each sample edge, shift SDI_s into the RX shift register and increment the bit counter (width clog2(DATA_W+1)).
    - On each shift edge, present the next TX bit on SDO. For CPHA=1, the first leading edge presents the first bit and performs no shift.
    - At counter == DATA_W: copy RX to RX_DATA, set RX_VALID, set OVERRUN if RX_VALID was already high (the new word overwrites), and clear the counter.
    - A word reloads the TX shift register as in LOAD, so bursts continue word after word while CS stays low.
    - For CPHA=0, the reload takes effect on the shift edge after the last sample, which presents the next word's first bit.
- CS_s rise in any state returns to IDLE within 1 cycle. A partial word is discarded: no RX_VALID, counter cleared, SDO=0. A loaded holding register is not consumed unless LOAD already occurred.
- Handshakes:
  - TX_VALID & TX_READY latches TX_DATA and drops TX_READY the next cycle.
  - RX_VALID & RX_READY clears RX_VALID the next cycle.
  - If a word completes in the same cycle as RX_READY & RX_VALID, the new word wins: RX_VALID stays high and there is no overrun.
- OVERRUN and UNDERRUN clear only on reset.
- SCLK edges while CS_s is high are ignored.

## Timing
- Reset values: SDO=0, TX_READY=1, RX_DATA=0, RX_VALID=0, BUSY=0, OVERRUN=0, UNDERRUN=0; state IDLE.
- Pin-to-edge-detect latency: SYNC_STAGES+1 cycles.
- SDO update latency: one cycle after the shift-edge detect.
- RX_VALID latency: rises one cycle after the detect of the final sample edge.
- CTRL_CLK must be ≥ 8× SCLK. The master must hold CS low ≥ 4 CTRL_CLK cycles before the first SCLK edge, and release it ≥ 4 cycles after the last edge.
- Reset mid-transfer: all state returns to reset values on the next CTRL_CLK edge, regardless of CS.

## Test plan
- Mode 0, DATA_W=8, preload TX 0xA5, master sends 0x3C → master receives 0xA5; RX_DATA=0x3C; RX_VALID held until RX_READY.
- All four CPOL/CPHA combinations, DATA_W=16, LSB-first, TX 0x8001 and master 0x1234 → exchange is bit-exact in every mode.
- Burst of 3 words under one CS, TX 0x11/0x22/0x33 loaded just in time, RX_READY held high → three RX_VALID pulses with 0x..., no flags; SDO continuous across word boundaries.
- Burst of 2 words with RX_READY low → OVERRUN=1 and RX_DATA equals word 2. With no TX preload → first word on SDO is 0x00 and UNDERRUN=1.
- CS deasserted after 5 of 8 bits, then a full 0x5A transfer → no RX_VALID after the abort; the next transfer receives 0x5A correctly.
- NRST pulsed low mid-word → all outputs at reset values next cycle; a subsequent transfer is correct.

Source files
------------

// File: rtl/spi_slave_param.sv
// spi_slave_param: oversampled SPI slave for all four CPOL/CPHA modes.
// Word-wide TX holding register, RX output register, sticky error flags.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CTRL_CLK,
  input  logic              NRST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              SDI,
  output logic              SDO,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic              BUSY,
  output logic              OVERRUN,
  output logic              UNDERRUN
);
  localparam int   CW  = $clog2(DATA_W + 1);
  localparam logic POL = (CPOL != 0);
  localparam logic PHA = (CPHA != 0);
  localparam logic MSB = (MSB_FIRST != 0);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   cs_prev_q;
  logic                   sclk_prev_q;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   sdi_s;

  state_t            state_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] rx_sr_d;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              sdo_q;
  logic [CW-1:0]     cnt_q;
  logic              pend_q;
  logic              uflag_q;
  logic              ovr_q;
  logic              und_q;

  logic              sclk_rise;
  logic              sclk_fall;
  logic              lead;
  logic              trail;
  logic              samp;
  logic              shft;
  logic              cs_fall;
  logic              last_bit;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] shift_src;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    first_bit = MSB ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
    drop_bit = MSB ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= {SYNC_STAGES{POL}};
      sdi_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= POL;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], SDI};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign lead      = POL ? sclk_fall : sclk_rise;
  assign trail     = POL ? sclk_rise : sclk_fall;
  assign samp      = PHA ? trail : lead;
  assign shft      = PHA ? lead : trail;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign last_bit  = (cnt_q == CW'(DATA_W - 1));
  assign load_word = hold_full_q ? hold_q : '0;
  // CPHA=0 reloads on the shift edge that follows a completed word
  assign shift_src = pend_q ? load_word : tx_sr_q;
  assign rx_sr_d   = MSB ? {rx_sr_q[DATA_W-2:0], sdi_s}
                         : {sdi_s, rx_sr_q[DATA_W-1:1]};

  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      sdo_q       <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      uflag_q     <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      if (TX_VALID && !hold_full_q) begin
        hold_q      <= TX_DATA;
        hold_full_q <= 1'b1;
      end
      if (rx_valid_q && RX_READY) rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sdo_q   <= 1'b0;
          cnt_q   <= '0;
          pend_q  <= 1'b0;
          uflag_q <= 1'b0;
          if (cs_fall) state_q <= LOAD;
        end
        LOAD: begin
          if (cs_s) begin
            state_q <= IDLE;
          end else begin
            tx_sr_q <= PHA ? load_word : drop_bit(load_word);
            if (!PHA) sdo_q <= first_bit(load_word);
            if (hold_full_q) hold_full_q <= 1'b0;
            else             und_q       <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            state_q <= IDLE;
            sdo_q   <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            uflag_q <= 1'b0;
          end else begin
            if (samp) begin
              rx_sr_q <= rx_sr_d;
              // an empty reload only counts once the next word really starts
              if (uflag_q) begin
                und_q   <= 1'b1;
                uflag_q <= 1'b0;
              end
              if (last_bit) begin
                cnt_q      <= '0;
                rx_data_q  <= rx_sr_d;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !RX_READY) ovr_q <= 1'b1;
                if (PHA) begin
                  tx_sr_q <= load_word;
                  if (hold_full_q) hold_full_q <= 1'b0;
                  else             uflag_q     <= 1'b1;
                end else begin
                  pend_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            if (shft) begin
              sdo_q   <= first_bit(shift_src);
              tx_sr_q <= drop_bit(shift_src);
              if (pend_q) begin
                pend_q <= 1'b0;
                if (hold_full_q) hold_full_q <= 1'b0;
                else             uflag_q     <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SDO      = sdo_q;
  assign TX_READY = ~hold_full_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign BUSY     = (state_q != IDLE);
  assign OVERRUN  = ovr_q;
  assign UNDERRUN = und_q;
endmodule
